// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row strobe, column sync, frame capture,
// and a press/release debouncer that emits one hex code per physical press.
module keypad_scanner #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int         N  = CLK_HZ / SCAN_HZ;
  localparam int         DW = $clog2(N);
  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_DB} state_t;

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    r_q, r_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    s1_q, s2_q;
  logic [15:0]   snap_q, snap_d;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

  logic          tick, frame_end, single;
  logic [15:0]   frame;
  logic [4:0]    nbits;
  logic [3:0]    hit_idx, code, cnt_inc;

  // Bit index is row*4 + col, col 0 leftmost.
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:  key_code = 4'h1;
      4'd1:  key_code = 4'h2;
      4'd2:  key_code = 4'h3;
      4'd3:  key_code = 4'hA;
      4'd4:  key_code = 4'h4;
      4'd5:  key_code = 4'h5;
      4'd6:  key_code = 4'h6;
      4'd7:  key_code = 4'hB;
      4'd8:  key_code = 4'h7;
      4'd9:  key_code = 4'h8;
      4'd10: key_code = 4'h9;
      4'd11: key_code = 4'hC;
      4'd12: key_code = 4'h0;
      4'd13: key_code = 4'hF;
      4'd14: key_code = 4'hE;
      default: key_code = 4'hD;
    endcase
  endfunction

  always_comb begin
    tick   = (div_q == DW'(N - 1));
    div_d  = tick ? '0 : div_q + 1'b1;
    r_d    = r_q;
    row_d  = row_q;
    snap_d = snap_q;
    if (tick) begin
      snap_d[{r_q, 2'b00} +: 4] = ~s2_q;
      r_d   = r_q + 2'd1;
      row_d = ~(4'b0001 << r_d);
    end
    // The frame-end tick sees row 3 through snap_d, not the stale snap_q.
    frame     = snap_d;
    frame_end = tick && (r_q == 2'd3);

    nbits   = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        nbits   = nbits + 5'd1;
        hit_idx = 4'(i);
      end
    end
    single  = (nbits == 5'd1);
    code    = key_code(hit_idx);
    cnt_inc = (cnt_q >= DB) ? DB : cnt_q + 4'd1;

    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (single) begin
            cand_d = code;
            cnt_d  = 4'd1;
            if (DB == 4'd1) begin
              key_d   = code;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = PRESSED;
            end else begin
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (single && code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB) begin
              key_d   = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = PRESSED;
            end
          end else if (single) begin
            cand_d = code;
            cnt_d  = 4'd1;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (!(single && code == key_q)) begin
            cnt_d = 4'd1;
            if (DB == 4'd1) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              state_d = REL_DB;
            end
          end
        end
        default: begin
          if (single && code == key_q) begin
            cnt_d   = '0;
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc;
            // Releasing frame never seeds a new candidate; next key starts from IDLE.
            if (cnt_inc >= DB) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_q   <= '0;
      r_q     <= '0;
      row_q   <= 4'b1110;
      s1_q    <= 4'hF;
      s2_q    <= 4'hF;
      snap_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      r_q     <= r_d;
      row_q   <= row_d;
      s1_q    <= col;
      s2_q    <= s1_q;
      snap_q  <= snap_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign row       = row_q;
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner at N=4 (16-cycle frames), two-frame debounce.
module tb_keypad_scanner;

  logic       clk;
  logic       clr_n;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic [15:0] keys;

  keypad_scanner #(.CLK_HZ(16), .SCAN_HZ(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .clr_n(clr_n), .col(col), .row(row),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive switch matrix: a pressed key shorts its row drive onto its column.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  typedef struct { logic [15:0] keys; logic [3:0] code; } code_vec_t;
  typedef struct { int cyc; logic [3:0] row; } row_vec_t;
  code_vec_t codes[16];
  row_vec_t  rows[6];

  int ntot, npass;
  int cyc, pulses, last_pulse, consec, held_seen;
  logic prev_v;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clear_stats();
    cyc = 0; pulses = 0; last_pulse = -1; consec = 0; held_seen = 0; prev_v = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (key_valid) begin
      pulses++;
      last_pulse = cyc;
      if (prev_v) consec++;
    end
    if (key_held) held_seen++;
    prev_v = key_valid;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset off-edge, hold two cycles, release on a negedge so edge 1 is the first count.
  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    clear_stats();
  endtask

  initial begin
    ntot = 0; npass = 0;
    clear_stats();
    keys  = '0;
    clr_n = 1'b0;

    codes[0]  = '{16'h0001, 4'h1};  codes[1]  = '{16'h0002, 4'h2};
    codes[2]  = '{16'h0004, 4'h3};  codes[3]  = '{16'h0008, 4'hA};
    codes[4]  = '{16'h0010, 4'h4};  codes[5]  = '{16'h0020, 4'h5};
    codes[6]  = '{16'h0040, 4'h6};  codes[7]  = '{16'h0080, 4'hB};
    codes[8]  = '{16'h0100, 4'h7};  codes[9]  = '{16'h0200, 4'h8};
    codes[10] = '{16'h0400, 4'h9};  codes[11] = '{16'h0800, 4'hC};
    codes[12] = '{16'h1000, 4'h0};  codes[13] = '{16'h2000, 4'hF};
    codes[14] = '{16'h4000, 4'hE};  codes[15] = '{16'h8000, 4'hD};
    rows[0] = '{0, 4'b1110};  rows[1] = '{3, 4'b1110};  rows[2] = '{4, 4'b1101};
    rows[3] = '{8, 4'b1011};  rows[4] = '{12, 4'b0111}; rows[5] = '{16, 4'b1110};

    // Reset values while held in reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_row", 16'(row), 16'hE);
    chk("rst_key", 16'(key), 16'h0);
    chk("rst_valid", 16'(key_valid), 16'h0);
    chk("rst_held", 16'(key_held), 16'h0);
    clr_n = 1'b1;
    clear_stats();

    // Row strobe sequence
    for (int i = 0; i < 6; i++) begin
      while (cyc < rows[i].cyc) step();
      chk($sformatf("row_scan_c%0d", rows[i].cyc), 16'(row), 16'(rows[i].row));
    end

    // Every key position decodes to its hex code
    for (int i = 0; i < 16; i++) begin
      do_reset();
      keys = codes[i].keys;
      run(32);
      chk($sformatf("code_pulse_%0d", i), 16'(pulses), 16'd1);
      chk($sformatf("code_key_%0d", i), 16'(key), 16'(codes[i].code));
      keys = '0;
    end

    // Clean press of '5'
    do_reset();
    keys = 16'h0020;
    run(64);
    chk("press5_pulses", 16'(pulses), 16'd1);
    chk("press5_when", 16'(last_pulse), 16'd32);
    chk("press5_key", 16'(key), 16'h5);
    chk("press5_held", 16'(key_held), 16'd1);
    keys = '0;
    run(31);
    chk("rel5_held_before", 16'(key_held), 16'd1);
    step();
    chk("rel5_held_after", 16'(key_held), 16'd0);
    chk("rel5_key_kept", 16'(key), 16'h5);
    chk("press5_consec", 16'(consec), 16'd0);

    // Bounce on '9'
    do_reset();
    for (int f = 0; f < 8; f++) begin
      keys = (f % 2 == 0) ? 16'h0400 : 16'h0000;
      run(16);
    end
    chk("bounce_pulses", 16'(pulses), 16'd0);
    chk("bounce_held", 16'(held_seen), 16'd0);
    keys = '0;

    // Ghost A+B, then A alone
    do_reset();
    keys = 16'h0088;
    run(64);
    chk("ghost_pulses", 16'(pulses), 16'd0);
    chk("ghost_held", 16'(held_seen), 16'd0);
    keys = 16'h0008;
    run(32);
    chk("ghost_a_pulses", 16'(pulses), 16'd1);
    chk("ghost_a_when", 16'(last_pulse), 16'd96);
    chk("ghost_a_key", 16'(key), 16'hA);
    keys = '0;

    // 'D' held, then change to '0'
    do_reset();
    keys = 16'h8000;
    run(32);
    chk("d_pulse", 16'(pulses), 16'd1);
    chk("d_key", 16'(key), 16'hD);
    keys = 16'h1000;
    run(31);
    chk("chg_held_before", 16'(key_held), 16'd1);
    step();
    chk("chg_held_after", 16'(key_held), 16'd0);
    chk("chg_no_early", 16'(pulses), 16'd1);
    run(32);
    chk("zero_pulses", 16'(pulses), 16'd2);
    chk("zero_when", 16'(last_pulse), 16'd96);
    chk("zero_key", 16'(key), 16'h0);
    chk("zero_held", 16'(key_held), 16'd1);
    chk("chg_consec", 16'(consec), 16'd0);
    keys = '0;

    // Reset while '7' is held
    do_reset();
    keys = 16'h0100;
    run(40);
    chk("hold7_held", 16'(key_held), 16'd1);
    chk("hold7_key", 16'(key), 16'h7);
    clr_n = 1'b0;
    #1;
    chk("midrst_row", 16'(row), 16'hE);
    chk("midrst_key", 16'(key), 16'h0);
    chk("midrst_valid", 16'(key_valid), 16'h0);
    chk("midrst_held", 16'(key_held), 16'h0);
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    clear_stats();
    run(31);
    chk("rearm_no_early", 16'(pulses), 16'd0);
    step();
    chk("rearm_pulse", 16'(pulses), 16'd1);
    chk("rearm_key", 16'(key), 16'h7);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
